// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 Hz VGA timing source.
// Line/frame layout is sync pulse, back porch, visible region, front porch.
package vga_timing_pkg;

    // Pixel divider default: 100 MHz system clock down to a 25 MHz pixel rate
    localparam int CLK_DIV_DEF   = 4;

    // Horizontal layout in pixels
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;

    // Vertical layout in lines
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;

    // Derived totals and visible window bounds (end values are exclusive)
    localparam int H_TOTAL       = H_SYNC_DEF + H_BP_DEF + H_VISIBLE_DEF + H_FP_DEF;
    localparam int V_TOTAL       = V_SYNC_DEF + V_BP_DEF + V_VISIBLE_DEF + V_FP_DEF;
    localparam int H_VIS_START   = H_SYNC_DEF + H_BP_DEF;
    localparam int H_VIS_END     = H_VIS_START + H_VISIBLE_DEF;
    localparam int V_VIS_START   = V_SYNC_DEF + V_BP_DEF;
    localparam int V_VIS_END     = V_VIS_START + V_VISIBLE_DEF;

    // Counter step that rolls over to zero after the last value of the span
    function automatic logic [9:0] wrapInc(input logic [9:0] count, input logic [9:0] last);
        return (count == last) ? 10'd0 : count + 10'd1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// Pixel-rate enable generator: one ClkPort-wide pulse every CLK_DIV clocks.
// pix_en is registered so it sits low during reset even when CLK_DIV is 1.
module pix_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic ClkPort,
    input  logic Reset_n,
    output logic pix_en
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div;
    logic [3:0] divNext;

    // Next divider phase, wrapping after the last phase of a pixel period
    always_comb begin
        divNext = (div == DIV_LAST) ? 4'd0 : div + 4'd1;
    end

    // Divider phase and enable, high exactly while the phase is the last one
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            div    <= 4'd0;
            pix_en <= 1'b0;
        end else begin
            div    <= divNext;
            pix_en <= (divNext == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: pixel divider, horizontal/vertical counters, registered
// sync/bright decode and line/frame strobes.
// Optional build macro VGA_TIMING_PIPE_EN delays hSync/vSync/bright by one
// pixel to line up with a one-pixel-latency RGB lookup downstream.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF
) (
    input  logic       ClkPort,
    input  logic       Reset_n,
    output logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       line_start,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_SYNC + H_BP + H_VISIBLE + H_FP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_SYNC + V_BP + V_VISIBLE + V_FP - 1);
    localparam logic [9:0] HS_END   = 10'(H_SYNC);
    localparam logic [9:0] VS_END   = 10'(V_SYNC);
    localparam logic [9:0] HV_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HV_END   = 10'(H_SYNC + H_BP + H_VISIBLE);
    localparam logic [9:0] VV_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VV_END   = 10'(V_SYNC + V_BP + V_VISIBLE);

    logic [9:0] hcNext;
    logic [9:0] vcNext;
    logic       lineWrap;
    logic       frameWrap;
    logic       hSyncNext;
    logic       vSyncNext;
    logic       brightNext;
    logic       hSyncR;
    logic       vSyncR;
    logic       brightR;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) uPixTick (
        .ClkPort (ClkPort),
        .Reset_n (Reset_n),
        .pix_en  (pix_en)
    );

    // Next counter values and their decode, so registered outputs track hc/vc
    always_comb begin
        lineWrap   = (hc == H_LAST);
        frameWrap  = lineWrap && (vc == V_LAST);
        hcNext     = wrapInc(hc, H_LAST);
        vcNext     = lineWrap ? wrapInc(vc, V_LAST) : vc;
        hSyncNext  = !(hcNext < HS_END);
        vSyncNext  = !(vcNext < VS_END);
        brightNext = (hcNext >= HV_START) && (hcNext < HV_END) &&
                     (vcNext >= VV_START) && (vcNext < VV_END);
    end

    // Pixel coordinates advance once per pixel enable
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            hc <= 10'd0;
            vc <= 10'd0;
        end else if (pix_en) begin
            hc <= hcNext;
            vc <= vcNext;
        end
    end

    // Sync and visible-window flags registered alongside the counters
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            hSyncR  <= 1'b1;
            vSyncR  <= 1'b1;
            brightR <= 1'b0;
        end else if (pix_en) begin
            hSyncR  <= hSyncNext;
            vSyncR  <= vSyncNext;
            brightR <= brightNext;
        end
    end

    // Line/frame strobes last one ClkPort cycle, on the edge the wrap happens
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en && lineWrap;
            frame_start <= pix_en && frameWrap;
        end
    end

`ifdef VGA_TIMING_PIPE_EN
    logic hSyncD;
    logic vSyncD;
    logic brightD;

    // Extra pixel-enabled stage delaying the decode by exactly one pixel
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            hSyncD  <= 1'b1;
            vSyncD  <= 1'b1;
            brightD <= 1'b0;
        end else if (pix_en) begin
            hSyncD  <= hSyncR;
            vSyncD  <= vSyncR;
            brightD <= brightR;
        end
    end

    assign hSync  = hSyncD;
    assign vSync  = vSyncD;
    assign bright = brightD;
`else
    assign hSync  = hSyncR;
    assign vSync  = vSyncR;
    assign bright = brightR;
`endif

endmodule
